// File: rtl/alu_shift_sequencer_pkg.sv
// Shared op encodings and FSM state type for the ALU shift/rotate sequencer.
// Optional feature macro used by the sequencer: ALU_SEQ_AMT_MOD_EN.
package alu_seq_pkg;

  localparam logic [1:0] OP_ROR = 2'b00;
  localparam logic [1:0] OP_ROL = 2'b01;
  localparam logic [1:0] OP_LSR = 2'b10;
  localparam logic [1:0] OP_LSL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Rotates occupy the lower half of the op encoding.
  function automatic logic is_rotate(input logic [1:0] op);
    return ~op[1];
  endfunction

endpackage

// File: rtl/alu_shift_sequencer_if.sv
// Request/response bundle between the issue logic and the shift sequencer.
// master = issuing side, slave = the sequencer.
interface alu_shift_sequencer_if #(
  parameter int LEN   = 8,
  parameter int AMT_W = 4
);

  logic             start_valid;
  logic             start_ready;
  logic [1:0]       op;
  logic [LEN-1:0]   a;
  logic [AMT_W-1:0] amt;
  logic             res_valid;
  logic             res_ready;
  logic [LEN-1:0]   result;
  logic             n;
  logic             c;
  logic             z;
  logic             v;
  logic             busy;

  modport master (
    output start_valid, op, a, amt, res_ready,
    input  start_ready, res_valid, result, n, c, z, v, busy
  );

  modport slave (
    input  start_valid, op, a, amt, res_ready,
    output start_ready, res_valid, result, n, c, z, v, busy
  );

endinterface

// File: rtl/alu_shift_sequencer_step.sv
// Combinational single-bit shift/rotate step; bit_out is the bit that leaves
// the word (bit 0 for right moves, bit LEN-1 for left moves).
module alu_shift1_step
  import alu_seq_pkg::*;
#(
  parameter int LEN = 8
) (
  input  logic [1:0]     op,
  input  logic [LEN-1:0] data,
  output logic [LEN-1:0] data_out,
  output logic           bit_out
);

  always_comb begin
    data_out = data;
    bit_out  = 1'b0;
    case (op)
      OP_ROR: begin
        data_out = {data[0], data[LEN-1:1]};
        bit_out  = data[0];
      end
      OP_ROL: begin
        data_out = {data[LEN-2:0], data[LEN-1]};
        bit_out  = data[LEN-1];
      end
      OP_LSR: begin
        data_out = {1'b0, data[LEN-1:1]};
        bit_out  = data[0];
      end
      default: begin
        data_out = {data[LEN-2:0], 1'b0};
        bit_out  = data[LEN-1];
      end
    endcase
  end

endmodule

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: one 1-bit step per clock, result and NCZV
// flags returned over a valid/ready handshake. Macro ALU_SEQ_AMT_MOD_EN reduces amounts.
module alu_shift_sequencer
  import alu_seq_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int AMT_W = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_shift_sequencer_if.slave bus
);

  state_t           r_state;
  logic [LEN-1:0]   r_data;
  logic [1:0]       r_op;
  logic [AMT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_ovf;
  logic             r_clr_c;
  logic [LEN-1:0]   r_result;
  logic             r_n;
  logic             r_c;
  logic             r_z;
  logic             r_v;
  logic             r_res_valid;
  logic             r_start_ready;
  logic             r_busy;

  logic [LEN-1:0]   w_step_data;
  logic             w_step_bit;
  logic [AMT_W-1:0] w_eff_amt;
  logic             w_clr_c;

  alu_shift1_step #(.LEN(LEN)) u_step (
    .op       (r_op),
    .data     (r_data),
    .data_out (w_step_data),
    .bit_out  (w_step_bit)
  );

`ifdef ALU_SEQ_AMT_MOD_EN
  always_comb begin
    if (is_rotate(bus.op))
      w_eff_amt = AMT_W'(int'(bus.amt) % LEN);
    else if (int'(bus.amt) >= LEN)
      w_eff_amt = AMT_W'(LEN);
    else
      w_eff_amt = bus.amt;
  end
`else
  assign w_eff_amt = bus.amt;
`endif

  // A logical shift by LEN or more reports no carry, whatever the last step shifted out.
  assign w_clr_c = !is_rotate(bus.op) && (int'(bus.amt) >= LEN);

  // DONE spends its first cycle publishing result/flags, giving amt+1 latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_data        <= '0;
      r_op          <= OP_ROR;
      r_cnt         <= '0;
      r_carry       <= 1'b0;
      r_ovf         <= 1'b0;
      r_clr_c       <= 1'b0;
      r_result      <= '0;
      r_n           <= 1'b0;
      r_c           <= 1'b0;
      r_z           <= 1'b0;
      r_v           <= 1'b0;
      r_res_valid   <= 1'b0;
      r_start_ready <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_valid) begin
            r_data        <= bus.a;
            r_op          <= bus.op;
            r_cnt         <= w_eff_amt;
            r_carry       <= 1'b0;
            r_ovf         <= 1'b0;
            r_clr_c       <= w_clr_c;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= (w_eff_amt == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_data  <= w_step_data;
          r_carry <= w_step_bit;
          if (r_op == OP_LSL && (w_step_data[LEN-1] != r_data[LEN-1]))
            r_ovf <= 1'b1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == AMT_W'(1))
            r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (!r_res_valid) begin
            r_result    <= r_data;
            r_n         <= r_data[LEN-1];
            r_z         <= (r_data == '0);
            r_c         <= r_carry & ~r_clr_c;
            r_v         <= r_ovf;
            r_res_valid <= 1'b1;
          end else if (bus.res_ready) begin
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.start_ready = r_start_ready;
  assign bus.res_valid   = r_res_valid;
  assign bus.result      = r_result;
  assign bus.n           = r_n;
  assign bus.c           = r_c;
  assign bus.z           = r_z;
  assign bus.v           = r_v;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed self-checking bench for alu_shift_sequencer (LEN=8, AMT_W=4).
// Latency expectations follow ALU_SEQ_AMT_MOD_EN when it is defined.
module tb_alu_shift_sequencer;
  import alu_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   totalChecks;
  int   badChecks;
  int   lat;

  alu_shift_sequencer_if #(.LEN(8), .AMT_W(4)) bus ();

  alu_shift_sequencer #(.LEN(8), .AMT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issues one request and returns the number of edges after acceptance until res_valid.
  task automatic applyStimulus(input logic [1:0] o, input logic [7:0] av,
                               input logic [3:0] am, output int latency);
    latency = -1;
    @(negedge clk);
    checkOutput("ready_before_issue", {31'b0, bus.start_ready}, 32'd1);
    bus.start_valid = 1'b1;
    bus.op          = o;
    bus.a           = av;
    bus.amt         = am;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.res_valid) begin
        latency = k;
        break;
      end
    end
  endtask

  task automatic releaseResult();
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    checkOutput("drain_valid", {31'b0, bus.res_valid}, 32'd0);
    checkOutput("drain_ready", {31'b0, bus.start_ready}, 32'd1);
    checkOutput("drain_busy", {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic runVector(input string tag, input logic [1:0] o, input logic [7:0] av,
                           input logic [3:0] am, input logic [7:0] expRes,
                           input logic [3:0] expNczv, input int expLat);
    int l;
    applyStimulus(o, av, am, l);
    checkOutput({tag, "_lat"}, l, expLat);
    checkOutput({tag, "_res"}, {24'b0, bus.result}, {24'b0, expRes});
    checkOutput({tag, "_nczv"}, {28'b0, bus.n, bus.c, bus.z, bus.v}, {28'b0, expNczv});
    checkOutput({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
    releaseResult();
  endtask

  initial begin
    totalChecks     = 0;
    badChecks       = 0;
    rst_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.op          = OP_ROR;
    bus.a           = 8'h00;
    bus.amt         = 4'd0;
    bus.res_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", {31'b0, bus.start_ready}, 32'd1);
    checkOutput("rst_valid", {31'b0, bus.res_valid}, 32'd0);
    checkOutput("rst_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("rst_result", {24'b0, bus.result}, 32'd0);
    checkOutput("rst_nczv", {28'b0, bus.n, bus.c, bus.z, bus.v}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ROR 11111000 by 3, then hold the result under backpressure.
    applyStimulus(OP_ROR, 8'hF8, 4'd3, lat);
    checkOutput("ror3_lat", lat, 32'd4);
    checkOutput("ror3_res", {24'b0, bus.result}, 32'h1F);
    checkOutput("ror3_nczv", {28'b0, bus.n, bus.c, bus.z, bus.v}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start_valid = 1'b1;
      bus.op          = OP_LSL;
      bus.a           = 8'h55;
      bus.amt         = 4'd1;
      @(posedge clk);
      #1;
      checkOutput("bp_valid", {31'b0, bus.res_valid}, 32'd1);
      checkOutput("bp_ready", {31'b0, bus.start_ready}, 32'd0);
      checkOutput("bp_res", {24'b0, bus.result}, 32'h1F);
      checkOutput("bp_nczv", {28'b0, bus.n, bus.c, bus.z, bus.v}, 32'h0);
    end
    bus.start_valid = 1'b0;
    releaseResult();
    checkOutput("bp_res_after", {24'b0, bus.result}, 32'h1F);

    runVector("rol2",  OP_ROL, 8'h33, 4'd2, 8'hCC, 4'b1000, 3);
    runVector("lsr5",  OP_LSR, 8'h1E, 4'd5, 8'h00, 4'b0110, 6);
    runVector("lsl1",  OP_LSL, 8'h40, 4'd1, 8'h80, 4'b1001, 2);
    runVector("lsl1c", OP_LSL, 8'h81, 4'd1, 8'h02, 4'b0101, 2);
    runVector("ror0",  OP_ROR, 8'h00, 4'd0, 8'h00, 4'b0010, 1);
`ifdef ALU_SEQ_AMT_MOD_EN
    runVector("lsr12", OP_LSR, 8'hFF, 4'd12, 8'h00, 4'b0010, 9);
    runVector("rol8",  OP_ROL, 8'h80, 4'd8, 8'h80, 4'b1000, 1);
    runVector("ror9",  OP_ROR, 8'h03, 4'd9, 8'h81, 4'b1100, 2);
`else
    runVector("lsr12", OP_LSR, 8'hFF, 4'd12, 8'h00, 4'b0010, 13);
    runVector("rol8",  OP_ROL, 8'h80, 4'd8, 8'h80, 4'b1000, 9);
    runVector("ror9",  OP_ROR, 8'h03, 4'd9, 8'h81, 4'b1100, 10);
`endif

    // Reset in the middle of a long operation.
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.op          = OP_ROR;
    bus.a           = 8'hFF;
    bus.amt         = 4'd12;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("mid_busy", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_ready", {31'b0, bus.start_ready}, 32'd1);
    checkOutput("mrst_valid", {31'b0, bus.res_valid}, 32'd0);
    checkOutput("mrst_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("mrst_result", {24'b0, bus.result}, 32'd0);
    checkOutput("mrst_nczv", {28'b0, bus.n, bus.c, bus.z, bus.v}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      checkOutput("post_rst_valid", {31'b0, bus.res_valid}, 32'd0);
    end
    checkOutput("post_rst_ready", {31'b0, bus.start_ready}, 32'd1);

    runVector("after_rst", OP_ROL, 8'h01, 4'd3, 8'h08, 4'b0000, 4);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
